// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (majority vote per bit) feeding a one-entry valid/ready buffer.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (sense set by PARITY_ODD).
module uart_rx_os #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  uart_rx,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_VOTE = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_os: OVERSAMPLE must be even and >= 4, PARITY_ODD must be 0 or 1");
    end

    // Two-flop synchroniser, idle-high so reset never looks like a start bit
    logic sync1_reg;
    logic sync2_reg;
    logic rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= uart_rx;
            sync2_reg <= sync1_reg;
        end
    end

    assign rx_s = sync2_reg;

    logic [2:0]            state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [BW-1:0]         bit_reg, bit_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [1:0]            early_reg, early_next;
    logic                  vote;
    logic                  at_vote;
    logic                  at_last;
    logic                  deliver;
    logic                  frame_bad;

    // The two earlier samples are held; the third is the live rx_s at the vote point
    assign vote    = (early_reg[1] & early_reg[0]) | (early_reg[1] & rx_s) | (early_reg[0] & rx_s);
    assign at_vote = (cnt_reg == CNT_VOTE);
    assign at_last = (cnt_reg == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_bad_reg, par_bad_next;
    logic parity_bad;
    logic parity_err_reg;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        early_next = early_reg;
        deliver    = 1'b0;
        frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad_reg;
        parity_bad   = 1'b0;
`endif
        if (cnt_reg == CNT_PRE) early_next[0] = rx_s;
        if (cnt_reg == CNT_MID) early_next[1] = rx_s;
        if (state_reg != ST_IDLE && state_reg != ST_BREAK)
            cnt_next = at_last ? '0 : cnt_reg + CNT_ONE;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_START: begin
                if (at_vote && vote) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (at_last) begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (at_vote)
                    shift_next = DATA_WIDTH'({vote, shift_reg} >> 1);
                if (at_last) begin
                    if (bit_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_vote)
                    par_bad_next = vote ^ (^shift_reg) ^ PAR_ODD;
                if (at_last)
                    state_next = ST_STOP;
            end
`endif
            // STOP resolves at the vote point so the next start bit is never missed
            ST_STOP: begin
                if (at_vote) begin
                    cnt_next = '0;
                    if (!vote) begin
                        frame_bad  = 1'b1;
                        state_next = ST_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_reg) begin
                        parity_bad = 1'b1;
                        state_next = ST_IDLE;
`endif
                    end else begin
                        deliver    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s)
                    state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            early_reg <= 2'b11;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            early_reg <= early_next;
        end
    end

    logic [DATA_WIDTH-1:0] m_data_reg;
    logic                  m_valid_reg;
    logic                  frame_err_reg;
    logic                  overrun_reg;

    // A read in the delivery cycle frees the slot, so load and read can coincide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data_reg    <= '0;
            m_valid_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= frame_bad;
            overrun_reg   <= 1'b0;
            if (deliver) begin
                if (!m_valid_reg || m_ready) begin
                    m_data_reg  <= shift_reg;
                    m_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (m_valid_reg && m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            par_bad_reg    <= par_bad_next;
            parity_err_reg <= parity_bad;
        end
    end

    assign parity_error = parity_err_reg;
`else
    assign parity_error = 1'b0;
`endif

    assign m_data      = m_data_reg;
    assign m_valid     = m_valid_reg;
    assign frame_error = frame_err_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: frames are built bit by bit and outcomes predicted from frame rules.
// Honours UART_RX_PARITY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int DW   = 8;
    localparam int OS   = 8;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // cycles from driving the start bit on uart_rx to the result being visible
    localparam int LAT   = 2 + (1 + DW + P) * OS + OS / 2 + 2;
    localparam int FRAME = (2 + DW + P) * OS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          uart_rx = 1'b1;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          frame_error;
    logic          parity_error;
    logic          overrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int            hs_cyc[$];
    logic [DW-1:0] hs_data[$];
    int            rise_cyc[$];
    int            fe_cyc[$];
    int            pe_cyc[$];
    int            ov_cyc[$];
    int            vld_cnt = 0;
    int            unstable = 0;
    logic          prev_hold = 1'b0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] prev_data = '0;

    uart_rx_os #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .PARITY_ODD(PODD)) dut (
        .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .frame_error(frame_error), .parity_error(parity_error), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (m_valid) vld_cnt++;
            if (m_valid && !prev_valid) rise_cyc.push_back(cyc);
            if (m_valid && m_ready) begin
                hs_cyc.push_back(cyc);
                hs_data.push_back(m_data);
            end
            if (frame_error)  fe_cyc.push_back(cyc);
            if (parity_error) pe_cyc.push_back(cyc);
            if (overrun)      ov_cyc.push_back(cyc);
            if (prev_hold && m_valid && m_data !== prev_data) unstable++;
        end
        prev_hold  = reset_n && m_valid && !m_ready;
        prev_valid = reset_n && m_valid;
        prev_data  = m_data;
    end

    function automatic logic good_par(input logic [DW-1:0] d);
        return (^d) ^ (PODD != 0);
    endfunction

    task automatic clear_events();
        hs_cyc = {}; hs_data = {}; rise_cyc = {};
        fe_cyc = {}; pe_cyc = {}; ov_cyc = {};
        vld_cnt = 0; unstable = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        step(n);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par_bit, input logic stop_bit,
                              output int start_cyc);
        logic bits[$];
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (P == 1) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        start_cyc = cyc;
        foreach (bits[i]) begin
            uart_rx = bits[i];
            step(OS);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            uart_rx = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (m_valid !== 1'b0 || m_data !== '0 || frame_error !== 1'b0 ||
                parity_error !== 1'b0 || overrun !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: m_valid=%b m_data=%h fe=%b pe=%b ov=%b, required all zero",
                         m_valid, m_data, frame_error, parity_error, overrun);
            end
            @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        m_ready = 1'b1;
        step(1);
        clear_events();
        reset_n = 1'b1;
        idle(100);
        vectors++;
        if (vld_cnt != 0 || fe_cyc.size() != 0 || pe_cyc.size() != 0 || ov_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL reset_idle: valid cycles=%0d fe=%0d pe=%0d ov=%0d, required none",
                     vld_cnt, fe_cyc.size(), pe_cyc.size(), ov_cyc.size());
        end
    endtask

    task automatic test_single();
        int s;
        m_ready = 1'b1;
        clear_events();
        send_frame(8'hA5, good_par(8'hA5), 1'b1, s);
        idle(2 * OS);
        vectors++;
        if (hs_cyc.size() != 1) begin
            miscompares++;
            $display("FAIL single_count: got %0d bytes, required 1", hs_cyc.size());
        end else begin
            vectors++;
            if (hs_data[0] !== 8'hA5) begin
                miscompares++;
                $display("FAIL single_data: got %h, required a5", hs_data[0]);
            end
            vectors++;
            if (hs_cyc[0] != s + LAT) begin
                miscompares++;
                $display("FAIL single_latency: valid at cycle %0d, required %0d", hs_cyc[0], s + LAT);
            end
        end
        vectors++;
        if (vld_cnt != 1) begin
            miscompares++;
            $display("FAIL single_pulse: m_valid high %0d cycles, required 1", vld_cnt);
        end
        vectors++;
        if (fe_cyc.size() + pe_cyc.size() + ov_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL single_errors: %0d error pulses, required 0",
                     fe_cyc.size() + pe_cyc.size() + ov_cyc.size());
        end
    endtask

    task automatic test_random();
        int            s;
        int            exp_cyc[$];
        logic [DW-1:0] exp_data[$];
        int            exp_pe[$];
        logic [DW-1:0] d;
        logic          par;
        m_ready = 1'b1;
        clear_events();
        for (int n = 0; n < 16; n++) begin
            d   = DW'($urandom);
            par = good_par(d);
            if (P == 1 && $urandom_range(0, 3) == 0) par = ~par;
            send_frame(d, par, 1'b1, s);
            if (par != good_par(d) && P == 1) begin
                exp_pe.push_back(s + LAT);
            end else begin
                exp_cyc.push_back(s + LAT);
                exp_data.push_back(d);
            end
            idle(OS * $urandom_range(0, 2) + $urandom_range(0, 3));
        end
        idle(2 * OS);
        vectors++;
        if (hs_cyc.size() != exp_cyc.size()) begin
            miscompares++;
            $display("FAIL random_count: got %0d bytes, required %0d", hs_cyc.size(), exp_cyc.size());
        end
        for (int i = 0; i < hs_cyc.size() && i < exp_cyc.size(); i++) begin
            vectors++;
            if (hs_data[i] !== exp_data[i] || hs_cyc[i] != exp_cyc[i]) begin
                miscompares++;
                $display("FAIL random_byte[%0d]: got %h at %0d, required %h at %0d",
                         i, hs_data[i], hs_cyc[i], exp_data[i], exp_cyc[i]);
            end
        end
        vectors++;
        if (pe_cyc != exp_pe || fe_cyc.size() != 0 || ov_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL random_errors: pe=%0d fe=%0d ov=%0d, required pe=%0d fe=0 ov=0",
                     pe_cyc.size(), fe_cyc.size(), ov_cyc.size(), exp_pe.size());
        end
    endtask

    task automatic test_glitch();
        int s;
        m_ready = 1'b1;
        clear_events();
        uart_rx = 1'b0;
        step(2);
        idle(4);
        // a real frame 6 cycles after the glitch must still be caught on time
        send_frame(8'h3C, good_par(8'h3C), 1'b1, s);
        idle(2 * OS);
        vectors++;
        if (hs_cyc.size() != 1 || fe_cyc.size() + pe_cyc.size() + ov_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_events: bytes=%0d errors=%0d, required 1 byte 0 errors",
                     hs_cyc.size(), fe_cyc.size() + pe_cyc.size() + ov_cyc.size());
        end else begin
            vectors++;
            if (hs_data[0] !== 8'h3C || hs_cyc[0] != s + LAT) begin
                miscompares++;
                $display("FAIL glitch_recover: got %h at %0d, required 3c at %0d",
                         hs_data[0], hs_cyc[0], s + LAT);
            end
        end
    endtask

    task automatic test_back_to_back_backpressure();
        int s1, s2;
        m_ready = 1'b0;
        clear_events();
        send_frame(8'h31, good_par(8'h31), 1'b1, s1);
        send_frame(8'h32, good_par(8'h32), 1'b1, s2);
        idle(OS);
        vectors++;
        if (rise_cyc.size() != 1 || (rise_cyc.size() == 1 && rise_cyc[0] != s1 + LAT)) begin
            miscompares++;
            $display("FAIL bp_first_valid: %0d rises, required one at %0d", rise_cyc.size(), s1 + LAT);
        end
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 8'h31) begin
            miscompares++;
            $display("FAIL bp_hold: m_valid=%b m_data=%h, required 1 and 31", m_valid, m_data);
        end
        vectors++;
        if (ov_cyc.size() != 1 || (ov_cyc.size() == 1 && ov_cyc[0] != s2 + LAT)) begin
            miscompares++;
            $display("FAIL bp_overrun: %0d pulses, required one at %0d", ov_cyc.size(), s2 + LAT);
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("FAIL bp_stable: m_data changed %0d times while held, required 0", unstable);
        end
        m_ready = 1'b1;
        idle(3 * FRAME);
        vectors++;
        if (hs_data.size() != 1 || (hs_data.size() == 1 && hs_data[0] !== 8'h31) || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: %0d bytes read, m_valid=%b, required only 31 and m_valid=0",
                     hs_data.size(), m_valid);
        end
    endtask

    task automatic test_break();
        int s1, s2;
        m_ready = 1'b1;
        clear_events();
        send_frame(8'h55, good_par(8'h55), 1'b0, s1);
        uart_rx = 1'b0;
        step(20 * OS);
        idle(2 * OS);
        send_frame(8'h0F, good_par(8'h0F), 1'b1, s2);
        idle(2 * OS);
        vectors++;
        if (fe_cyc.size() != 1 || (fe_cyc.size() == 1 && fe_cyc[0] != s1 + LAT)) begin
            miscompares++;
            $display("FAIL break_frame_error: %0d pulses, required one at %0d", fe_cyc.size(), s1 + LAT);
        end
        vectors++;
        if (hs_cyc.size() != 1 || (hs_cyc.size() == 1 && (hs_data[0] !== 8'h0F || hs_cyc[0] != s2 + LAT))) begin
            miscompares++;
            $display("FAIL break_recover: %0d bytes, required only 0f at %0d", hs_cyc.size(), s2 + LAT);
        end
        vectors++;
        if (pe_cyc.size() + ov_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL break_other: %0d other pulses, required 0", pe_cyc.size() + ov_cyc.size());
        end
    endtask

    task automatic test_midframe_reset();
        int s;
        m_ready = 1'b0;
        clear_events();
        send_frame(8'h5A, good_par(8'h5A), 1'b1, s);
        uart_rx = 1'b0;
        step(30);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || m_data !== '0) begin
            miscompares++;
            $display("FAIL midreset_async: m_valid=%b m_data=%h, required 0 and 00", m_valid, m_data);
        end
        uart_rx = 1'b1;
        @(posedge clk);
        #1;
        step(2);
        clear_events();
        reset_n = 1'b1;
        m_ready = 1'b1;
        idle(12 * OS);
        send_frame(8'hC3, good_par(8'hC3), 1'b1, s);
        idle(2 * OS);
        vectors++;
        if (hs_cyc.size() != 1 || (hs_cyc.size() == 1 && (hs_data[0] !== 8'hC3 || hs_cyc[0] != s + LAT))) begin
            miscompares++;
            $display("FAIL midreset_after: %0d bytes, required only c3 at %0d", hs_cyc.size(), s + LAT);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int s1, s2;
        m_ready = 1'b1;
        clear_events();
        send_frame(8'h07, 1'b0, 1'b1, s1);
        send_frame(8'h07, 1'b1, 1'b1, s2);
        idle(2 * OS);
        vectors++;
        if (pe_cyc.size() != 1 || (pe_cyc.size() == 1 && pe_cyc[0] != s1 + LAT)) begin
            miscompares++;
            $display("FAIL parity_error: %0d pulses, required one at %0d", pe_cyc.size(), s1 + LAT);
        end
        vectors++;
        if (hs_cyc.size() != 1 || (hs_cyc.size() == 1 && (hs_data[0] !== 8'h07 || hs_cyc[0] != s2 + LAT))) begin
            miscompares++;
            $display("FAIL parity_good: %0d bytes, required only 07 at %0d", hs_cyc.size(), s2 + LAT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_back_to_back_backpressure();
        test_break();
        test_random();
        test_midframe_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
